// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, limits and helpers for the APB completer
package apb_pkg;

  localparam int APB_WAIT_MAX = 15;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_completer_if.sv
// rtl/apb_completer_if.sv - APB bus bundle between controller and completer
// i_PSTRB exists only when APB_STRB_EN is defined.
interface apb_completer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                    i_PSEL;
  logic                    i_PENABLE;
  logic                    i_PWRITE;
  logic [ADDR_WIDTH-1:0]   i_PADDR;
  logic [DATA_WIDTH-1:0]   i_PWDATA;
`ifdef APB_STRB_EN
  logic [DATA_WIDTH/8-1:0] i_PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   o_PRDATA;
  logic                    o_PREADY;
  logic                    o_PSLVERR;

  modport master (
    output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
`ifdef APB_STRB_EN
    output i_PSTRB,
`endif
    input  o_PRDATA, o_PREADY, o_PSLVERR
  );

  modport slave (
    input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
`ifdef APB_STRB_EN
    input  i_PSTRB,
`endif
    output o_PRDATA, o_PREADY, o_PSLVERR
  );

endinterface

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word register file with byte-enable write and async read
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [IDX_W-1:0]        ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < LANES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_completer.sv
// rtl/apb_completer.sv - APB completer: FSM, wait counter, error check, registered outputs
// APB_STRB_EN enables byte strobes; otherwise every write updates the whole word.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic            i_PCLK,
  input  logic            i_PRESETn,
  apb_completer_if.slave  bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = lane_bits(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD =
      4'((WAIT_STATES > APB_WAIT_MAX) ? APB_WAIT_MAX : WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_ACCESS = ACCESS;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return ((a & LANE_MASK) != '0) || ((a >> LB) >= ADDR_WIDTH'(DEPTH));
  endfunction

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]      strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  setup, complete, err_in, wr_src, err_src;
  logic [IDX_W-1:0]      idx_in, ridx;
  logic [LANES-1:0]      strb_in;
  logic [DATA_WIDTH-1:0] rd_data;

`ifdef APB_STRB_EN
  assign strb_in = bus.i_PSTRB;
`else
  assign strb_in = '1;
`endif

  assign setup  = (state_q == S_IDLE) && bus.i_PSEL && !bus.i_PENABLE;
  assign err_in = addr_err(bus.i_PADDR);
  assign idx_in = bus.i_PADDR[LB +: IDX_W];
  // With zero wait states completion happens on the setup edge, before the latches load.
  assign ridx    = setup ? idx_in : idx_q;
  assign wr_src  = setup ? bus.i_PWRITE : wr_q;
  assign err_src = setup ? err_in : err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    complete = 1'b0;
    if (state_q == S_IDLE) begin
      if (setup) begin
        state_d  = S_ACCESS;
        cnt_d    = WAIT_LD;
        wr_d     = bus.i_PWRITE;
        err_d    = err_in;
        idx_d    = idx_in;
        wdata_d  = bus.i_PWDATA;
        strb_d   = strb_in;
        complete = (WAIT_LD == 4'd0);
      end
    end else if (pready_q) begin
      state_d = S_IDLE;
    end else if (!bus.i_PSEL || !bus.i_PENABLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (cnt_q <= 4'd1) begin
      cnt_d    = '0;
      complete = 1'b1;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
    pready_d  = complete;
    pslverr_d = complete && err_src;
    prdata_d  = (complete && !wr_src && !err_src) ? rd_data : '0;
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Commit lands on the edge that closes the PREADY cycle.
  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk_i   (i_PCLK),
    .rst_ni  (i_PRESETn),
    .we_i    (pready_q && wr_q && !err_q),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (ridx),
    .rdata_o (rd_data)
  );

  assign bus.o_PREADY  = pready_q;
  assign bus.o_PSLVERR = pslverr_q;
  assign bus.o_PRDATA  = prdata_q;

endmodule

// File: doc/apb_completer.md
# apb_completer

APB completer (slave) with a word-addressed register file. It answers the transfers issued by the team's APB controller behind `controller_wrapper`, closing the loop so the bench exercises both ends of the bus. It supports:
- a programmable number of wait states;
- PSLVERR on out-of-range or misaligned addresses;
- optional APB4 byte strobes.

## Interface
- `ADDR_WIDTH`, default 8: PADDR width; byte address.
- `DATA_WIDTH`, default 32: PWDATA/PRDATA width; multiple of 8, at least 16.
- `DEPTH`, default 16: number of DATA_WIDTH registers; power of two, at most 2^(ADDR_WIDTH-LANE_BITS).
- `WAIT_STATES`, default 0: access cycles with PREADY low before completion; 0..15.

Ports:
- `i_PCLK` in, 1: sole clock, rising edge.
- `i_PRESETn` in, 1: asynchronous, active-low reset.
- `i_PSEL` in, 1: completer select.
- `i_PENABLE` in, 1: access phase.
- `i_PWRITE` in, 1: 1 = write, 0 = read.
- `i_PADDR` in, ADDR_WIDTH: byte address.
- `i_PWDATA` in, DATA_WIDTH: write data.
- `i_PSTRB` in, DATA_WIDTH/8: byte write strobes; present only with `APB_STRB_EN`.
- `o_PRDATA` out, DATA_WIDTH: read data; valid while PREADY=1 on a read.
- `o_PREADY` out, 1: transfer completes this cycle.
- `o_PSLVERR` out, 1: error; valid only while PREADY=1.

## Operation
- Definitions: LANE_BITS = log2(DATA_WIDTH/8); word index = PADDR[ADDR_WIDTH-1:LANE_BITS].
- FSM states: IDLE, ACCESS.
- IDLE → ACCESS: PSEL=1 and PENABLE=0 (setup cycle). On that edge the block:
  - latches PWRITE, PADDR, PWDATA and PSTRB;
  - evaluates the error flag;
  - loads the wait counter with WAIT_STATES.
- In ACCESS with counter > 0: decrement the counter; PREADY stays 0.
- Completion: at the edge where the counter reaches 0 (or immediately, when WAIT_STATES=0), register PREADY=1, PSLVERR=err and PRDATA.
  - Read without error: PRDATA = mem[index].
  - Otherwise: PRDATA = 0.
- Error flag = (PADDR[LANE_BITS-1:0] != 0) OR (index >= DEPTH).
- Errored writes leave memory unchanged.
- Write commit: mem[index] is updated on the edge that ends the PREADY=1 cycle. Only bytes whose PSTRB bit is set are written.
- After completion: next cycle PREADY=0, PSLVERR=0, PRDATA=0; FSM returns to IDLE.
- Back-to-back transfers: a new setup cycle immediately following completion is accepted normally.
- Abort: PSEL=0 or PENABLE=0 while in ACCESS and before completion. The FSM returns to IDLE, nothing is written and PREADY stays 0.
- PSEL=1 with PENABLE=1 while in IDLE (no setup cycle) is ignored; the block waits for a proper setup cycle.
- Input changes during ACCESS are ignored; the values latched at setup are used.

## Timing
- Reset values (asynchronous, immediate): FSM=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0.
- Setup cycle T1, first access cycle T2. PREADY is high in cycle T2+WAIT_STATES for exactly one cycle.
- Total transfer length: 2+WAIT_STATES cycles; no idle cycle is required between transfers.
- Read-after-write to the same address in the next transfer returns the new data.
- Reset asserted mid-transfer: the transfer is dropped, including a write whose PREADY cycle has not ended.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `APB_STRB_EN`.
- Defined:
  - `i_PSTRB` port exists.
  - A write with PSTRB=0 is legal and changes nothing.
- Undefined:
  - `i_PSTRB` port is absent.
  - Every write updates the full word, with internal strobes all ones.

## Structure
- Package `apb_pkg`:
  - state enum `apb_state_t` {IDLE, ACCESS};
  - LANE_BITS calculation function;
  - `APB_WAIT_MAX` = 15.
- Sub-module `apb_regfile`:
  - DEPTH×DATA_WIDTH storage with asynchronous clear;
  - byte-enable write port and combinational read port;
  - instantiated once.
- Top level: FSM, wait counter, error check and output registers.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x04 and read 0x04 (WAIT_STATES=0): each transfer takes 2 cycles; the read returns 0xDEADBEEF with PSLVERR=0.
- WAIT_STATES=3, read of address 0x08 after reset: PREADY first high 4 cycles after setup; PRDATA=0x00000000.
- Access to address 0x40 with DEPTH=16, and to misaligned address 0x05: PSLVERR=1 with PREADY, PRDATA=0; a subsequent read of 0x04 shows the word unchanged.
- With `APB_STRB_EN`: write 0x11223344 with PSTRB=4'b1111, then 0xAABBCCDD with PSTRB=4'b0101; a read returns 0x11BB33DD.
- PSEL dropped in the second access cycle of a write with WAIT_STATES=2: no PREADY; memory unchanged; the next transfer completes normally.
- PRESETn pulsed low during a wait state: all outputs 0 immediately; memory cleared; a later read returns 0.
